pla_illegal_trap_ctrl: RTL

- Downstream consumer of the pipe-1 illegal-opcode decode flag (pillegalopc).
- Turns a valid illegal instruction in pipe stage 1 into a precise trap:
  - kills the offending instruction;
  - freezes the front end while older instructions drain;
  - raises a held trap request to the exception unit via a req/ack handshake.
- Keeps a saturating illegal-opcode counter and a sticky masked-event flag for debug.

---
 rtl/pla_illegal_trap_ctrl_pkg.sv | 28 ++
 rtl/pla_illegal_trap_ctrl_sat_counter.sv | 34 +++
 rtl/pla_illegal_trap_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pla_illegal_trap_ctrl_pkg.sv
// Shared types and constants for the illegal-opcode trap controller and
// the other trap sources that report to the exception unit.
package pla_illegal_trap_ctrl_pkg;

  localparam int DEFAULT_OPW = 10;
  localparam int DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REQ,
    ST_RESUME
  } trap_state_e;

  typedef enum logic [7:0] {
    CAUSE_NONE        = 8'h00,
    CAUSE_FETCH_FAULT = 8'h01,
    CAUSE_ILLEGAL_OPC = 8'h02,
    CAUSE_BREAKPOINT  = 8'h03,
    CAUSE_ECALL       = 8'h0B
  } trap_cause_e;

  // The drain counter counts down to zero, so it is loaded with cycles-1.
  function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int cycles);
    return DRAIN_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pla_illegal_trap_ctrl_sat_counter.sv
// W-bit saturating event counter with synchronous clear; clear beats increment.
module pla_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pla_illegal_trap_ctrl.sv
// Turns a pipe-1 illegal opcode into a precise trap: kill, freeze, drain,
// then a held req/ack trap request to the exception unit.
module pla_illegal_trap_ctrl
  import pla_illegal_trap_ctrl_pkg::*;
#(
  parameter int         OPW           = DEFAULT_OPW,
  parameter int         DRAIN_CYCLES  = 2,
  parameter int         CNTW          = 8,
  parameter logic [7:0] CAUSE_ILLEGAL = CAUSE_ILLEGAL_OPC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe1_valid,
  input  logic [OPW-1:0]  pipe1_opcode,
  input  logic            pillegalopc,
  input  logic            pipe_stall,
  input  logic            trap_enable,
  input  logic            trap_ack,
  input  logic            flag_clr,
  output logic            pipe1_kill,
  output logic            pipe_freeze,
  output logic            trap_req,
  output logic [7:0]      trap_cause,
  output logic [OPW-1:0]  trap_opcode,
  output logic [CNTW-1:0] illegal_count,
  output logic            illegal_masked
);

  trap_state_e            state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [OPW-1:0]         opcode_q, opcode_d;
  logic [7:0]             cause_q, cause_d;
  logic                   kill_q, kill_d;
  logic                   freeze_q, freeze_d;
  logic                   req_q, req_d;
  logic                   masked_q, masked_d;
  logic                   det;
  logic                   trap_start;
  logic                   masked_hit;

  // Outputs are derived from the next state so every one of them is a flop.
  always_comb begin
    det         = pipe1_valid & pillegalopc & ~pipe_stall;
    trap_start  = (state_q == ST_IDLE) & det & trap_enable;
    masked_hit  = (state_q == ST_IDLE) & det & ~trap_enable;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    opcode_d    = opcode_q;

    case (state_q)
      ST_IDLE: begin
        if (trap_start) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = drain_load(DRAIN_CYCLES);
          opcode_d    = pipe1_opcode;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_REQ;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    kill_d   = trap_start;
    freeze_d = (state_d != ST_IDLE);
    req_d    = (state_d == ST_REQ);
    cause_d  = req_d ? CAUSE_ILLEGAL : CAUSE_NONE;
    // A masked detection in the same cycle as a clear keeps the flag set.
    masked_d = (masked_q & ~flag_clr) | masked_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      opcode_q    <= '0;
      cause_q     <= '0;
      kill_q      <= 1'b0;
      freeze_q    <= 1'b0;
      req_q       <= 1'b0;
      masked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      opcode_q    <= opcode_d;
      cause_q     <= cause_d;
      kill_q      <= kill_d;
      freeze_q    <= freeze_d;
      req_q       <= req_d;
      masked_q    <= masked_d;
    end
  end

  pla_sat_counter #(
    .W(CNTW)
  ) u_illegal_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (trap_start),
    .count(illegal_count)
  );

  assign pipe1_kill     = kill_q;
  assign pipe_freeze    = freeze_q;
  assign trap_req       = req_q;
  assign trap_cause     = cause_q;
  assign trap_opcode    = opcode_q;
  assign illegal_masked = masked_q;

endmodule
